// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding for the bit-serial ALU engine.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // ADD and SUB are the only opcodes that propagate a carry.
  function automatic logic is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational one-bit ALU slice; SUB expects b already inverted by the caller.
module serial_alu_slice
  import alu_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  output logic       o_sum,
  output logic       o_cout
);

  always_comb begin
    o_sum  = 1'b0;
    o_cout = 1'b0;
    case (i_op)
      OP_AND: o_sum = i_a & i_b;
      OP_OR:  o_sum = i_a | i_b;
      default: begin
        o_sum  = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_engine.sv
// Bit-serial W-bit ALU, one bit per clock LSB first, start/done handshake.
// Optional signed overflow output enabled by SERIAL_ALU_OVF_EN.
//
// state  | meaning
// S_IDLE | waiting for start; result/flags hold last completed values
// S_RUN  | one operand bit per cycle through the slice
// S_DONE | one-cycle done pulse with fresh result/flags
module serial_alu_engine
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
`ifdef SERIAL_ALU_OVF_EN
  output logic         zero,
  output logic         ovf
`else
  output logic         zero
`endif
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [W-1:0]   r_res_sh;
  logic [1:0]     r_op;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_result;
  logic           r_c_out;
  logic           r_zero;
  logic           w_b_bit;
  logic           w_sum;
  logic           w_cout;
  logic           w_last;
  logic [W-1:0]   w_res_next;

  assign w_b_bit    = r_b_sh[0] ^ (r_op == OP_SUB);
  assign w_res_next = {w_sum, r_res_sh[W-1:1]};
  assign w_last     = (r_cnt == CNT_LAST);

  serial_alu_slice u_slice (
    .i_op   (r_op),
    .i_a    (r_a_sh[0]),
    .i_b    (w_b_bit),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Result/flags are committed on the last RUN edge so they are valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_op     <= OP_AND;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_op     <= op;
            r_carry  <= (op == OP_SUB);
            r_cnt    <= '0;
            r_res_sh <= '0;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          r_carry  <= w_cout;
          if (w_last) begin
            r_result <= w_res_next;
            r_c_out  <= w_cout;
            r_zero   <= (w_res_next == '0);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic r_ovf;

  // On the MSB cycle r_carry is the carry into the MSB and w_cout the carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= is_arith(r_op) & (r_carry ^ w_cout);
    end
  end

  assign ovf = r_ovf;
`endif

  assign result = r_result;
  assign c_out  = r_c_out;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_alu_engine.sv
// Scoreboard bench for serial_alu_engine (W=8); ovf checks when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu_engine;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         zero;
`ifdef SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  serial_alu_engine #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
`ifdef SERIAL_ALU_OVF_EN
    .zero   (zero),
    .ovf    (ovf)
`else
    .zero   (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [17:0] ARITH_TBL [5] = '{
    {OP_ADD, 8'hFF, 8'h01},
    {OP_SUB, 8'h05, 8'h07},
    {OP_SUB, 8'h07, 8'h05},
    {OP_ADD, 8'h80, 8'h80},
    {OP_SUB, 8'h3C, 8'h3C}
  };

  localparam logic [17:0] LOGIC_TBL [3] = '{
    {OP_AND, 8'hA5, 8'h0F},
    {OP_AND, 8'hF0, 8'h0F},
    {OP_OR,  8'hA0, 8'h0A}
  };

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    exp_t e;
    e = '0;
    case (o)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_ADD: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      default: begin
        s     = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Drives one request in IDLE and pushes its expected outcome.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0;
      op    = 2'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end
  endtask

  // Called right after the accepting edge; counts edges until done is seen.
  task automatic wait_done(output int lat, output bit ok, output logic [W-1:0] run_res, output logic run_busy);
    lat      = 0;
    ok       = 1'b0;
    run_res  = 'x;
    run_busy = 1'bx;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run_res  = result;
        run_busy = busy;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    op    = OP_ADD;
    a     = 8'h12;
    b     = 8'h34;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || c_out !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h c_out=%b zero=%b, required all 0",
               busy, done, result, c_out, zero);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_add_sub();
    int          lat;
    bit          ok;
    logic [W-1:0] rr;
    logic        rb;
    logic [17:0] v;
    exp_t        e;
    exp_t        prev;
    prev = '0;
    for (int i = 0; i < 5; i++) begin
      v = ARITH_TBL[i];
      issue(v[17:16], v[15:8], v[7:0], 1'b0);
      wait_done(lat, ok, rr, rb);
      n_tests++;
      if (!ok || lat != W) begin
        n_fail++;
        $display("FAIL arith_latency[%0d]: seen=%0b edges=%0d, required done after %0d edges", i, ok, lat, W);
      end
      n_tests++;
      if (rb !== 1'b1 || rr !== prev.res) begin
        n_fail++;
        $display("FAIL arith_hold[%0d]: busy=%b result=%h during RUN, required 1 %h", i, rb, rr, prev.res);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_tests++;
      if (result !== e.res || c_out !== e.c || zero !== e.z) begin
        n_fail++;
        $display("FAIL arith[%0d]: result=%h c_out=%b zero=%b, required %h %b %b",
                 i, result, c_out, zero, e.res, e.c, e.z);
      end
`ifdef SERIAL_ALU_OVF_EN
      n_tests++;
      if (ovf !== e.v) begin
        n_fail++;
        $display("FAIL arith_ovf[%0d]: ovf=%b, required %b", i, ovf, e.v);
      end
`endif
      prev = e;
    end
  endtask

  task automatic test_logic();
    int          lat;
    bit          ok;
    logic [W-1:0] rr;
    logic        rb;
    logic [17:0] v;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      v = LOGIC_TBL[i];
      issue(v[17:16], v[15:8], v[7:0], 1'b0);
      wait_done(lat, ok, rr, rb);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_tests++;
      if (!ok || result !== e.res || c_out !== e.c || zero !== e.z) begin
        n_fail++;
        $display("FAIL logic[%0d]: seen=%0b result=%h c_out=%b zero=%b, required %h %b %b",
                 i, ok, result, c_out, zero, e.res, e.c, e.z);
      end
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || result !== 8'hAA) begin
      n_fail++;
      $display("FAIL logic_after_done: done=%b result=%h, required 0 aa", done, result);
    end
  endtask

  task automatic test_random();
    int          lat;
    bit          ok;
    logic [W-1:0] rr;
    logic        rb;
    logic [1:0]  o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      issue(o, x, y, 1'b0);
      wait_done(lat, ok, rr, rb);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_tests++;
      if (!ok || result !== e.res || c_out !== e.c || zero !== e.z) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h c_out=%b zero=%b, required %h %b %b",
                 i, o, x, y, result, c_out, zero, e.res, e.c, e.z);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   dones;
    int   d1;
    int   d2;
    bit   pushed;
    exp_t e;
    dones  = 0;
    d1     = -1;
    d2     = -1;
    pushed = 1'b0;
    issue(OP_ADD, 8'h10, 8'h20, 1'b1);
    a = 8'h01;
    b = 8'h01;
    for (int i = 0; i < 3 * W + 6; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (dones == 1) d1 = i;
        else            d2 = i;
        n_tests++;
        if (result !== e.res || c_out !== e.c || zero !== e.z) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: result=%h c_out=%b zero=%b, required %h %b %b",
                   dones, result, c_out, zero, e.res, e.c, e.z);
        end
        if (dones == 2) break;
      end else if (!busy && dones == 1 && !pushed) begin
        sb.push_back(model(OP_ADD, 8'h01, 8'h01));
        pushed = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    n_tests++;
    if (dones != 2 || d1 != W || d2 - d1 != W + 2) begin
      n_fail++;
      $display("FAIL b2b_timing: dones=%0d first=%0d gap=%0d, required 2 %0d %0d", dones, d1, d2 - d1, W, W + 2);
    end
    start = 1'b0;
  endtask

  task automatic test_rst_midrun();
    int dones;
    issue(OP_ADD, 8'h33, 8'h44, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || c_out !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_midrun: busy=%b done=%b result=%h c_out=%b zero=%b, required all 0",
               busy, done, result, c_out, zero);
    end
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: active cycles=%0d, required 0", dones);
    end
  endtask

`ifdef SERIAL_ALU_OVF_EN
  task automatic test_ovf();
    int          lat;
    bit          ok;
    logic [W-1:0] rr;
    logic        rb;
    exp_t        e;
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0);
    wait_done(lat, ok, rr, rb);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_tests++;
    if (!ok || result !== 8'h80 || ovf !== 1'b1 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_add: result=%h ovf=%b c_out=%b, required 80 1 0", result, ovf, c_out);
    end
    issue(OP_SUB, 8'h80, 8'h01, 1'b0);
    wait_done(lat, ok, rr, rb);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_tests++;
    if (!ok || result !== 8'h7F || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sub: result=%h ovf=%b, required 7f 1", result, ovf);
    end
    issue(OP_AND, 8'hFF, 8'hFF, 1'b0);
    wait_done(lat, ok, rr, rb);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_tests++;
    if (!ok || result !== 8'hFF || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_and: result=%h ovf=%b, required ff 0", result, ovf);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_AND;
    a     = '0;
    b     = '0;
    test_reset();
    test_add_sub();
    test_logic();
    test_rst_midrun();
    test_random();
    test_back_to_back();
`ifdef SERIAL_ALU_OVF_EN
    test_ovf();
`endif
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
